// File: rtl/ap_ctrl_perf_pkg.sv
// ap_ctrl_perf_pkg: shared types and saturating helpers for the ap_ctrl performance monitor
package ap_ctrl_perf_pkg;
   localparam int STAT_W = 64;
   localparam int HIST_BINS = 8;
   typedef enum logic [1:0] {IDLE, BUSY, DONE_WAIT} ch_state_e;
   // Fields are sized for the widest configuration; live bits are set by CNT_W/LAT_W.
   typedef struct packed {
      logic [STAT_W-1:0] issue;
      logic [STAT_W-1:0] txn;
      logic [STAT_W-1:0] busy;
      logic [STAT_W-1:0] stall;
      logic [STAT_W-1:0] lat_min;
      logic [STAT_W-1:0] lat_max;
   } ch_stats_t;
   function automatic logic [STAT_W-1:0] all_ones(input int w);
      return (w >= STAT_W) ? '1 : (STAT_W'(1) << w) - STAT_W'(1);
   endfunction
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input int w);
      return (v == all_ones(w)) ? v : v + STAT_W'(1);
   endfunction
endpackage

// File: rtl/ap_ctrl_ch_tracker.sv
// ap_ctrl_ch_tracker: one channel's ap_ctrl_hs FSM and statistics; PERF_MON_HIST_EN adds a latency histogram
module ap_ctrl_ch_tracker
   import ap_ctrl_perf_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int LAT_W = 24
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      ap_start,
   input  logic      ap_ready,
   input  logic      ap_done,
   input  logic      ap_continue,
   input  logic      clear,
   input  logic      frozen,
   output logic      idle,
   output ch_stats_t stats
`ifdef PERF_MON_HIST_EN
   ,
   output logic [HIST_BINS-1:0][CNT_W-1:0] hist
`endif
);
   localparam ch_stats_t STATS_RST = '{issue: '0, txn: '0, busy: '0, stall: '0,
                                       lat_min: all_ones(LAT_W), lat_max: '0};
   ch_state_e state, nxt;
   logic [STAT_W-1:0] lat_cur, lat_eff, lat_done;
   logic is_idle, is_busy, complete, start_new;
   always_comb begin
      is_idle = state == IDLE;
      is_busy = state == BUSY;
      idle = is_idle;
      lat_eff = sat_inc(lat_cur, LAT_W);
      complete = is_idle ? ap_start && ap_done && ap_continue
               : is_busy ? ap_done && ap_continue : ap_continue;
      // Latency includes the done cycle itself; DONE_WAIT cycles do not advance it.
      lat_done = is_idle ? STAT_W'(1) : is_busy ? lat_eff : lat_cur;
      start_new = ap_start && (is_idle || complete);
      nxt = is_idle ? (!ap_start ? IDLE : !ap_done ? BUSY : ap_continue ? IDLE : DONE_WAIT)
          : is_busy && !ap_done ? BUSY
          : !ap_continue ? DONE_WAIT
          : ap_start ? BUSY : IDLE;
   end
`ifdef PERF_MON_HIST_EN
   logic [2:0] bin;
   always_comb begin
      bin = '0;
      for (int i = 1; i < HIST_BINS; i++) if (lat_done >= (STAT_W'(1) << i)) bin = 3'(i);
   end
`endif
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         lat_cur <= '0;
         stats <= STATS_RST;
`ifdef PERF_MON_HIST_EN
         hist <= '0;
`endif
      end else begin
         state <= nxt;
         lat_cur <= start_new ? STAT_W'(1) : is_busy ? lat_eff : lat_cur;
         if (!frozen && clear) begin
            stats <= STATS_RST;
`ifdef PERF_MON_HIST_EN
            hist <= '0;
`endif
         end else if (!frozen) begin
            if (ap_start && ap_ready) stats.issue <= sat_inc(stats.issue, CNT_W);
            if (is_busy) stats.busy <= sat_inc(stats.busy, CNT_W);
            if (state == DONE_WAIT) stats.stall <= sat_inc(stats.stall, CNT_W);
            if (complete) begin
               stats.txn <= sat_inc(stats.txn, CNT_W);
               if (lat_done < stats.lat_min) stats.lat_min <= lat_done;
               if (lat_done > stats.lat_max) stats.lat_max <= lat_done;
`ifdef PERF_MON_HIST_EN
               hist[bin] <= CNT_W'(sat_inc(STAT_W'(hist[bin]), CNT_W));
`endif
            end
         end
      end
   end
endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor: per-channel ap_ctrl_hs statistics with registered readout; PERF_MON_HIST_EN adds rd_bin/rd_hist
module ap_ctrl_perf_monitor
   import ap_ctrl_perf_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int CNT_W  = 32,
   parameter  int LAT_W  = 24,
   localparam int CH_W   = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ap_start,
   input  logic [NUM_CH-1:0] ap_ready,
   input  logic [NUM_CH-1:0] ap_done,
   input  logic [NUM_CH-1:0] ap_continue,
   input  logic              finish,
   input  logic              clear,
   input  logic              rd_en,
   input  logic [CH_W-1:0]   rd_ch,
`ifdef PERF_MON_HIST_EN
   input  logic [2:0]        rd_bin,
   output logic [CNT_W-1:0]  rd_hist,
`endif
   output logic              rd_valid,
   output logic              rd_err,
   output logic [CNT_W-1:0]  rd_issue,
   output logic [CNT_W-1:0]  rd_txn,
   output logic [CNT_W-1:0]  rd_busy,
   output logic [CNT_W-1:0]  rd_stall,
   output logic [LAT_W-1:0]  rd_lat_min,
   output logic [LAT_W-1:0]  rd_lat_max,
   output logic              all_idle,
   output logic              finish_seen
);
   logic [NUM_CH-1:0] idle;
   ch_stats_t stats [NUM_CH];
   ch_stats_t rd_q;
   logic rd_ok;
`ifdef PERF_MON_HIST_EN
   logic [HIST_BINS-1:0][CNT_W-1:0] hist [NUM_CH];
`endif
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      ap_ctrl_ch_tracker #(.CNT_W(CNT_W), .LAT_W(LAT_W)) u_trk (
         .clock       (clock),
         .reset       (reset),
         .ap_start    (ap_start[c]),
         .ap_ready    (ap_ready[c]),
         .ap_done     (ap_done[c]),
         .ap_continue (ap_continue[c]),
         .clear       (clear),
         .frozen      (finish_seen),
         .idle        (idle[c]),
`ifdef PERF_MON_HIST_EN
         .hist        (hist[c]),
`endif
         .stats       (stats[c])
      );
   end
   assign all_idle = &idle;
   assign rd_ok = int'(rd_ch) < NUM_CH;
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_err <= 1'b0;
         rd_q <= '0;
         finish_seen <= 1'b0;
`ifdef PERF_MON_HIST_EN
         rd_hist <= '0;
`endif
      end else begin
         rd_valid <= rd_en;
         rd_err <= rd_en && !rd_ok;
         rd_q <= rd_en && rd_ok ? stats[rd_ch] : '0;
         finish_seen <= finish_seen || finish;
`ifdef PERF_MON_HIST_EN
         rd_hist <= rd_en && rd_ok ? hist[rd_ch][rd_bin] : '0;
`endif
      end
   end
   assign rd_issue = rd_q.issue[CNT_W-1:0];
   assign rd_txn = rd_q.txn[CNT_W-1:0];
   assign rd_busy = rd_q.busy[CNT_W-1:0];
   assign rd_stall = rd_q.stall[CNT_W-1:0];
   assign rd_lat_min = rd_q.lat_min[LAT_W-1:0];
   assign rd_lat_max = rd_q.lat_max[LAT_W-1:0];
   // Saturation keeps the bits above CNT_W/LAT_W at zero.
   logic unused_hi;
   assign unused_hi = ^{rd_q.issue[STAT_W-1:CNT_W], rd_q.txn[STAT_W-1:CNT_W], rd_q.busy[STAT_W-1:CNT_W],
                        rd_q.stall[STAT_W-1:CNT_W], rd_q.lat_min[STAT_W-1:LAT_W], rd_q.lat_max[STAT_W-1:LAT_W]};
endmodule

// File: doc/ap_ctrl_perf_monitor.md
Name: ap_ctrl_perf_monitor

Overview:
Synthesizable, parametrised successor to the simulation-only dataflow status monitor. Tracks ap_ctrl_hs handshakes (ap_start/ap_ready/ap_done/ap_continue) on NUM_CH HLS kernel instances in parallel. Per channel it keeps transaction, busy, stall and latency statistics, readable through a registered one-cycle readout port. Sits beside the kernels in the IP wrapper, so counters are usable on hardware and in co-sim.

Parameters:
NUM_CH, 4, number of monitored ap_ctrl channels (1..32)
CNT_W, 32, width of the issue, transaction, busy and stall counters (saturating)
LAT_W, 24, width of the per-transaction latency counter and of the min/max registers (saturating)

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high reset
ap_start  in  NUM_CH  per-channel ap_start
ap_ready  in  NUM_CH  per-channel ap_ready
ap_done  in  NUM_CH  per-channel ap_done
ap_continue  in  NUM_CH  per-channel ap_continue (tie 1 for non-dataflow kernels)
finish  in  1  end-of-run; freezes all statistics
clear  in  1  synchronous clear of statistics; FSM states are kept
rd_en  in  1  readout request
rd_ch  in  $clog2(NUM_CH) max 1  channel select
rd_valid  out  1  readout data valid, one cycle after rd_en
rd_err  out  1  with rd_valid: rd_ch >= NUM_CH
rd_issue  out  CNT_W  accepted starts (ap_start && ap_ready)
rd_txn  out  CNT_W  completed transactions
rd_busy  out  CNT_W  cycles in BUSY
rd_stall  out  CNT_W  cycles in DONE_WAIT
rd_lat_min  out  LAT_W  minimum transaction latency
rd_lat_max  out  LAT_W  maximum transaction latency
all_idle  out  1  every channel FSM is IDLE
finish_seen  out  1  sticky; finish has been sampled high

Behaviour:
- Reset: all FSMs go to IDLE. All counters and lat_max go to 0; lat_min goes to all-ones. rd_valid=0, rd_err=0, rd_* data=0, finish_seen=0. all_idle=1 in the cycle after reset.
- Per-channel FSM, states IDLE, BUSY, DONE_WAIT:
  - IDLE: if ap_start, go to BUSY and load lat_cur=1. If ap_done && ap_continue occur in that same cycle, complete with latency 1 and stay IDLE.
  - BUSY: busy++ and lat_cur++ each cycle.
    - ap_done && ap_continue: complete. Next state is BUSY (lat_cur reloaded to 1) if ap_start, else IDLE.
    - ap_done && !ap_continue: go to DONE_WAIT; lat_cur holds.
  - DONE_WAIT: stall++ each cycle. On ap_continue: complete. Next state is BUSY if ap_start, else IDLE.
- Complete: txn++; lat_min=min(lat_min,lat_cur); lat_max=max(lat_max,lat_cur). lat_cur counts the cycles from the accept cycle to the done cycle, inclusive; DONE_WAIT cycles are excluded.
- issue++ every cycle that ap_start && ap_ready, independent of FSM state.
- All counters saturate at their all-ones value; no wrap.
- clear: counters, lat_min and lat_max return to reset values; FSM states and lat_cur are kept. Any event in the same cycle as clear is dropped. If reset and clear coincide, reset applies.
- finish: once finish_seen=1, every counter and min/max register freezes. FSMs keep tracking, so all_idle stays accurate. Only reset clears finish_seen; clear does not unfreeze.
- Readout: rd_en in cycle N returns, in cycle N+1, a snapshot of the channel registers as they stood before the cycle-N update. rd_valid is a one-cycle pulse. rd_ch out of range gives rd_err=1 with all data 0. rd_en on consecutive cycles returns back-to-back results.
- lat_min reads all-ones until the first completion.

Optional Feature:
PERF_MON_HIST_EN
- Defined: each channel adds an 8-bin latency histogram of CNT_W-bit saturating bins. Bin index = min(floor(log2(lat)),7). Adds input rd_bin (3 bits) and output rd_hist (CNT_W), returned with the same timing as the other readout fields. Bins follow the same clear and finish rules.
- Undefined: no histogram logic and no rd_bin/rd_hist ports.

Decomposition:
- Package ap_ctrl_perf_pkg holds:
  - state enum ch_state_e (IDLE, BUSY, DONE_WAIT)
  - struct ch_stats_t (issue, txn, busy, stall, lat_min, lat_max)
  - localparam function sat_inc
  - HIST_BINS=8
- Sub-module ap_ctrl_ch_tracker: one channel's FSM, counters and optional histogram, instantiated NUM_CH times via generate. The top level holds the readout mux, the finish/clear fan-out and the all_idle reduction.

Test Plan:
- ch0: start accepted at cycle 10, done+continue at cycle 14 -> txn=1, busy=4, lat_min=lat_max=5, stall=0, issue=1.
- ch1: done at cycle 20 with continue low for 3 cycles -> stall=3, latency excludes the 3 stall cycles, state returns to IDLE, all_idle=1.
- ch2: start held high across done, 3 transactions of latency 2, 6, 4 -> txn=3, lat_min=2, lat_max=6, no IDLE cycle between transactions.
- Saturation with CNT_W=4: 20 back-to-back single-cycle transactions -> txn=15, issue=15. Then clear -> txn=0, lat_min=all-ones, FSM unaffected.
- finish pulse mid-transaction on ch3 -> counters frozen, later done leaves txn unchanged, finish_seen=1, all_idle tracks FSMs.
- Readout: rd_en with rd_ch=1 then rd_ch=NUM_CH on consecutive cycles -> valid channel-1 data, then rd_err=1 with zero data. Reset asserted mid-BUSY -> all outputs at reset values next cycle.
